// File: rtl/entropy_src_cond_arb.sv
// Shares one SHA3 conditioner between the HW entropy path and the FW override path:
// round-robin grant, word forwarding with a per-seed cap, and SHA3 start/process/done sequencing.
module entropy_src_cond_arb #(
  parameter int MsgWidth  = 64,
  parameter int RateWords = 13,
  parameter int MaxWords  = 64,
  localparam int CntW     = $clog2(MaxWords + 1),
  localparam int BlkW     = $clog2(RateWords)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic                local_escalate_i,
  input  logic                hw_req_i,
  input  logic                fw_req_i,
  output logic                hw_gnt_o,
  output logic                fw_gnt_o,
  input  logic                hw_valid_i,
  input  logic                fw_valid_i,
  input  logic [MsgWidth-1:0] hw_data_i,
  input  logic [MsgWidth-1:0] fw_data_i,
  output logic                hw_ready_o,
  output logic                fw_ready_o,
  input  logic                hw_process_i,
  input  logic                fw_process_i,
  output logic                sha3_start_o,
  output logic                sha3_valid_o,
  output logic [MsgWidth-1:0] sha3_data_o,
  input  logic                sha3_ready_i,
  output logic                sha3_process_o,
  input  logic                sha3_state_vld_i,
  output logic [3:0]          sha3_done_o,
  output logic                digest_vld_o,
  output logic                digest_owner_o,
  output logic [CntW-1:0]     word_cnt_o,
  output logic [BlkW-1:0]     blk_cnt_o,
  output logic                idle_o,
  output logic                err_o
);

  localparam logic [3:0] MuBi4True  = 4'h6;
  localparam logic [3:0] MuBi4False = 4'h9;

  // Sparse encoding so a single upset lands on an illegal code and traps to Error.
  typedef enum logic [5:0] {
    StIdle    = 6'b001010,
    StStart   = 6'b110100,
    StAbsorb  = 6'b011111,
    StProcess = 6'b100001,
    StWaitVld = 6'b000111,
    StDone    = 6'b111001,
    StFlush   = 6'b010000,
    StError   = 6'b101100
  } state_e;

  state_e          r_state;
  logic            r_owner;       // 0 = hw, 1 = fw
  logic            r_last_owner;
  logic            r_gnt;
  logic            r_start;
  logic            r_process;
  logic [3:0]      r_done;
  logic            r_dvld;
  logic            r_downer;
  logic            r_err;
  logic [CntW-1:0] r_word_cnt;
  logic [BlkW-1:0] r_blk_cnt;

  logic w_legal, w_active, w_absorb, w_fault;
  logic w_own_req, w_own_valid, w_own_proc, w_abort, w_ready, w_hs, w_pick;

  always_comb begin
    w_legal  = 1'b0;
    w_active = 1'b0;
    case (r_state)
      StIdle, StDone, StFlush, StError: w_legal = 1'b1;
      StStart, StAbsorb, StProcess, StWaitVld: begin
        w_legal  = 1'b1;
        w_active = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_fault     = r_err | ~w_legal;
  assign w_absorb    = (r_state == StAbsorb);
  assign w_own_req   = r_owner ? fw_req_i     : hw_req_i;
  assign w_own_valid = r_owner ? fw_valid_i   : hw_valid_i;
  assign w_own_proc  = r_owner ? fw_process_i : hw_process_i;
  assign w_abort     = ~enable_i | ~w_own_req;
  assign w_ready     = w_absorb & sha3_ready_i & ~w_fault & (r_word_cnt < CntW'(MaxWords));
  assign w_hs        = w_ready & w_own_valid;
  // Contested grant goes to whoever did not finish the last seed.
  assign w_pick      = (hw_req_i & fw_req_i) ? ~r_last_owner : fw_req_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= StIdle;
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
      r_gnt        <= 1'b0;
      r_start      <= 1'b0;
      r_process    <= 1'b0;
      r_done       <= MuBi4False;
      r_dvld       <= 1'b0;
      r_downer     <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_start   <= 1'b0;
      r_process <= 1'b0;
      r_done    <= MuBi4False;
      r_dvld    <= 1'b0;
      r_downer  <= 1'b0;
      if (local_escalate_i || !w_legal) begin
        r_state <= StError;
        r_err   <= 1'b1;
        r_gnt   <= 1'b0;
      end else if (w_active && w_abort) begin
        // Abort wins over a same-cycle process or digest-valid.
        r_state <= StFlush;
        r_done  <= MuBi4True;
      end else begin
        unique case (r_state)
          StIdle: if (enable_i && (hw_req_i || fw_req_i)) begin
            r_owner <= w_pick;
            r_gnt   <= 1'b1;
            r_start <= 1'b1;
            r_state <= StStart;
          end
          StStart: r_state <= StAbsorb;
          StAbsorb: if (w_own_proc && !w_own_valid) begin
            r_process <= 1'b1;
            r_state   <= StProcess;
          end
          StProcess: r_state <= StWaitVld;
          StWaitVld: if (sha3_state_vld_i) begin
            r_done   <= MuBi4True;
            r_dvld   <= 1'b1;
            r_downer <= r_owner;
            r_state  <= StDone;
          end
          StDone: begin
            r_last_owner <= r_owner;
            r_gnt        <= 1'b0;
            r_state      <= StIdle;
          end
          StFlush: begin
            r_gnt   <= 1'b0;
            r_state <= StIdle;
          end
          StError: r_err <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_word_cnt <= '0;
      r_blk_cnt  <= '0;
    end else if (r_state == StDone || r_state == StFlush) begin
      r_word_cnt <= '0;
      r_blk_cnt  <= '0;
    end else if (w_hs) begin
      r_word_cnt <= (r_word_cnt == CntW'(MaxWords)) ? r_word_cnt : r_word_cnt + 1'b1;
      r_blk_cnt  <= (r_blk_cnt == BlkW'(RateWords - 1)) ? '0 : r_blk_cnt + 1'b1;
    end
  end

  assign hw_gnt_o       = r_gnt & ~r_owner & ~w_fault;
  assign fw_gnt_o       = r_gnt &  r_owner & ~w_fault;
  assign hw_ready_o     = w_ready & ~r_owner;
  assign fw_ready_o     = w_ready &  r_owner;
  assign sha3_valid_o   = w_absorb & w_own_valid & ~w_fault;
  assign sha3_data_o    = r_owner ? fw_data_i : hw_data_i;
  assign sha3_start_o   = r_start & ~w_fault;
  assign sha3_process_o = r_process & ~w_fault;
  assign sha3_done_o    = w_fault ? MuBi4False : r_done;
  assign digest_vld_o   = r_dvld & ~w_fault;
  assign digest_owner_o = r_downer;
  assign word_cnt_o     = r_word_cnt;
  assign blk_cnt_o      = r_blk_cnt;
  assign idle_o         = (r_state == StIdle);
  assign err_o          = w_fault;

endmodule

// File: tb/tb_entropy_src_cond_arb.sv
// Scoreboard bench: drivers push expected SHA3 words and done events; a negedge monitor pops and compares.
module tb_entropy_src_cond_arb;
  localparam int MsgWidth = 64, RateWords = 13, MaxWords = 64;
  localparam logic [3:0] MUBI_T = 4'h6, MUBI_F = 4'h9;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic enable_i, local_escalate_i, hw_req_i, fw_req_i, hw_gnt_o, fw_gnt_o;
  logic hw_valid_i, fw_valid_i, hw_ready_o, fw_ready_o, hw_process_i, fw_process_i;
  logic [MsgWidth-1:0] hw_data_i, fw_data_i, sha3_data_o;
  logic sha3_start_o, sha3_valid_o, sha3_ready_i, sha3_process_o, sha3_state_vld_i;
  logic [3:0] sha3_done_o;
  logic digest_vld_o, digest_owner_o, idle_o, err_o;
  logic [6:0] word_cnt_o;
  logic [3:0] blk_cnt_o;

  entropy_src_cond_arb #(.MsgWidth(MsgWidth), .RateWords(RateWords), .MaxWords(MaxWords)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable_i), .local_escalate_i(local_escalate_i),
    .hw_req_i(hw_req_i), .fw_req_i(fw_req_i), .hw_gnt_o(hw_gnt_o), .fw_gnt_o(fw_gnt_o),
    .hw_valid_i(hw_valid_i), .fw_valid_i(fw_valid_i), .hw_data_i(hw_data_i), .fw_data_i(fw_data_i),
    .hw_ready_o(hw_ready_o), .fw_ready_o(fw_ready_o),
    .hw_process_i(hw_process_i), .fw_process_i(fw_process_i),
    .sha3_start_o(sha3_start_o), .sha3_valid_o(sha3_valid_o), .sha3_data_o(sha3_data_o),
    .sha3_ready_i(sha3_ready_i), .sha3_process_o(sha3_process_o), .sha3_state_vld_i(sha3_state_vld_i),
    .sha3_done_o(sha3_done_o), .digest_vld_o(digest_vld_o), .digest_owner_o(digest_owner_o),
    .word_cnt_o(word_cnt_o), .blk_cnt_o(blk_cnt_o), .idle_o(idle_o), .err_o(err_o)
  );

  typedef struct { bit dig; bit owner; int cnt; int blk; } done_t;
  logic [63:0] exp_words[$];
  done_t       exp_done[$];
  int n_tests = 0, n_fail = 0;
  int tb_acc, last_wait;
  bit tb_last = 1'b1;   // fw owns "last" out of reset
  bit rdy_rand = 1'b0;
  logic [63:0] mon_w;
  done_t       mon_d;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic report_fail(input string name, input int act, input int exp);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic own_ready(input bit o);
    return o ? fw_ready_o : hw_ready_o;
  endfunction

  function automatic logic own_gnt(input bit o);
    return o ? fw_gnt_o : hw_gnt_o;
  endfunction

  task automatic drive(input bit o, input logic v, input logic [63:0] d, input logic p);
    if (o) begin fw_valid_i = v; fw_data_i = d; fw_process_i = p; end
    else   begin hw_valid_i = v; hw_data_i = d; hw_process_i = p; end
  endtask

  task automatic set_req(input bit o, input logic r);
    if (o) fw_req_i = r; else hw_req_i = r;
  endtask

  // SHA3 backpressure generator.
  initial forever begin
    @(posedge clk); #1;
    sha3_ready_i = !rdy_rand || ($urandom_range(3) != 0);
  end

  // Monitor: every accepted word and every done pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (sha3_valid_o && sha3_ready_i && (hw_ready_o || fw_ready_o)) begin
        if (exp_words.size() == 0) report_fail("unexpected_word", 1, 0);
        else begin
          mon_w = exp_words.pop_front();
          check("word_data", sha3_data_o, mon_w);
        end
      end
      if (sha3_done_o != MUBI_F) begin
        if (exp_done.size() == 0) report_fail("unexpected_done", 1, 0);
        else begin
          mon_d = exp_done.pop_front();
          check("done_mubi", sha3_done_o, MUBI_T);
          check("digest_vld", digest_vld_o, mon_d.dig);
          if (mon_d.dig) check("digest_owner", digest_owner_o, mon_d.owner);
          check("done_word_cnt", word_cnt_o, mon_d.cnt);
          check("done_blk_cnt", blk_cnt_o, mon_d.blk);
        end
      end else if (digest_vld_o) report_fail("digest_without_done", 1, 0);
    end
  end

  task automatic send_word(input bit o, input bit proc);
    logic [63:0] d;
    int t;
    d = {$urandom, $urandom};
    drive(o, 1'b1, d, proc);
    if (tb_acc < MaxWords) begin
      exp_words.push_back(d);
      tb_acc++;
      t = 0;
      do begin @(negedge clk); t++; end while (!own_ready(o) && t < 200);
      if (!own_ready(o)) report_fail("ready_timeout", t, 0);
    end else begin
      @(negedge clk);
      check("sat_ready_low", own_ready(o), 1'b0);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_gnt(input bit o);
    last_wait = 0;
    while (!own_gnt(o) && last_wait < 20) begin @(posedge clk); #1; last_wait++; end
    check("gnt_owner", own_gnt(o), 1'b1);
    check("gnt_other_low", own_gnt(!o), 1'b0);
  endtask

  // am: 0 = complete, 1 = enable drop in WaitVld, 2 = req drop in WaitVld
  task automatic run_seed(input bit o, input int n, input bit pl, input int am);
    tb_acc = 0;
    set_req(o, 1'b1);
    wait_gnt(o);
    check("start_pulse", sha3_start_o, 1'b1);
    @(posedge clk); #1;
    check("start_single", sha3_start_o, 1'b0);
    for (int i = 0; i < n; i++) begin
      send_word(o, pl && (i == n - 1));
      if (i < n - 1 && $urandom_range(3) == 0) begin
        drive(o, 1'b0, '0, 1'b0);
        @(posedge clk); #1;
      end
    end
    check("word_cnt", word_cnt_o, tb_acc);
    check("blk_cnt", blk_cnt_o, tb_acc % RateWords);
    if (pl) check("proc_deferred", sha3_process_o, 1'b0);
    drive(o, 1'b0, '0, 1'b1);
    @(negedge clk); check("proc_not_early", sha3_process_o, 1'b0);
    @(negedge clk); check("proc_pulse", sha3_process_o, 1'b1);
    @(posedge clk); #1;
    drive(o, 1'b0, '0, 1'b0);
    check("proc_single", sha3_process_o, 1'b0);
    repeat ($urandom_range(3)) begin @(posedge clk); #1; end
    sha3_state_vld_i = 1'b1;
    if (am == 0) begin
      exp_done.push_back('{1'b1, o, tb_acc, tb_acc % RateWords});
      @(negedge clk); check("digest_not_early", digest_vld_o, 1'b0);
      @(posedge clk); #1;
      sha3_state_vld_i = 1'b0;
      check("digest_latency", digest_vld_o, 1'b1);
      set_req(o, 1'b0);
      tb_last = o;
    end else begin
      exp_done.push_back('{1'b0, 1'b0, tb_acc, tb_acc % RateWords});
      if (am == 1) enable_i = 1'b0; else set_req(o, 1'b0);
      @(posedge clk); #1;
      sha3_state_vld_i = 1'b0;
      set_req(o, 1'b0);
      check("flush_no_digest", digest_vld_o, 1'b0);
      check("flush_done", sha3_done_o, MUBI_T);
    end
    @(posedge clk); #1;
    enable_i = 1'b1;
    check("idle_after", idle_o, 1'b1);
    check("idle_word_cnt", word_cnt_o, 0);
    check("idle_blk_cnt", blk_cnt_o, 0);
    check("idle_gnt_low", own_gnt(o), 1'b0);
  endtask

  task automatic check_reset_state();
    check("rst_idle", idle_o, 1'b1);
    check("rst_err", err_o, 1'b0);
    check("rst_gnt", {hw_gnt_o, fw_gnt_o}, 2'b00);
    check("rst_done", sha3_done_o, MUBI_F);
    check("rst_pulses", {sha3_start_o, sha3_process_o, digest_vld_o, sha3_valid_o}, 4'b0);
    check("rst_cnt", {word_cnt_o, blk_cnt_o}, 11'd0);
  endtask

  initial begin
    bit w;
    enable_i = 1'b1; local_escalate_i = 1'b0; hw_req_i = 1'b0; fw_req_i = 1'b0;
    hw_valid_i = 1'b0; fw_valid_i = 1'b0; hw_data_i = '0; fw_data_i = '0;
    hw_process_i = 1'b0; fw_process_i = 1'b0; sha3_ready_i = 1'b1; sha3_state_vld_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); check_reset_state();
    @(posedge clk); #1; rst = 1'b0;
    check("idle_post_reset", idle_o, 1'b1);

    // Contested request right after reset: hw wins, fw follows with a one-cycle gap.
    fw_req_i = 1'b1;
    run_seed(1'b0, 13, 1'b0, 0);
    run_seed(1'b1, 4, 1'b0, 0);
    check("rr_gap", last_wait, 1);
    // Single hw seed of exactly one rate block.
    run_seed(1'b0, 13, 1'b0, 0);
    // Saturation at MaxWords.
    run_seed(1'b0, 70, 1'b0, 0);
    // process together with the last valid word.
    run_seed(1'b1, 5, 1'b1, 0);
    // Aborts in WaitVld.
    run_seed(1'b0, 7, 1'b0, 1);
    run_seed(1'b1, 3, 1'b0, 2);

    rdy_rand = 1'b1;
    repeat (12) begin
      int sc;
      sc = $urandom_range(2);
      if (sc == 2) begin
        w = !tb_last;
        set_req(!w, 1'b1);
        run_seed(w, $urandom_range(20, 1), 1'($urandom_range(1)), 0);
        run_seed(!w, $urandom_range(20, 1), 1'($urandom_range(1)), $urandom_range(2));
        check("rr_gap_rand", last_wait, 1);
      end else begin
        run_seed(sc[0], $urandom_range(30, 1), 1'($urandom_range(1)), $urandom_range(2));
      end
    end
    rdy_rand = 1'b0;

    // Escalation during Absorb.
    tb_acc = 0;
    hw_req_i = 1'b1;
    wait_gnt(1'b0);
    @(posedge clk); #1;
    send_word(1'b0, 1'b0);
    send_word(1'b0, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0);
    local_escalate_i = 1'b1;
    @(posedge clk); #1;
    local_escalate_i = 1'b0;
    check("esc_err", err_o, 1'b1);
    check("esc_gnt", hw_gnt_o, 1'b0);
    check("esc_not_idle", idle_o, 1'b0);
    drive(1'b0, 1'b1, 64'h1234_5678_9abc_def0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      check("err_sticky", err_o, 1'b1);
      check("err_outputs_low", {hw_gnt_o, hw_ready_o, sha3_valid_o, sha3_process_o, digest_vld_o}, 5'b0);
      check("err_done_false", sha3_done_o, MUBI_F);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    hw_req_i = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0);
    @(negedge clk); check_reset_state();
    @(posedge clk); #1; rst = 1'b0;

    check("words_drained", exp_words.size(), 0);
    check("done_drained", exp_done.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
